// File: rtl/fifo_pkg.sv
// Default geometry shared by the FIFO top and its storage sub-module.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, one write port and one
// registered read port. The array itself is never reset; only the read
// register is cleared so the output is defined straight out of reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_p1;

  // Write port: capture data into the addressed entry.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---- stage p1: registered read, holds its value when no read occurs ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_p1;

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without an occupancy counter. Requests against a full
// or empty FIFO are dropped and flagged with a one-cycle error pulse.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             wr_error_o,
  output logic             rd_error_o
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic               wr_accept;
  logic               rd_accept;
  logic               wr_error_p1;
  logic               rd_error_p1;

  // Flags derive from the registered pointers only, so they describe the
  // state left by the most recent edge; the wrap bit separates full/empty.
  always_comb begin
    empty_o   = (wr_ptr == rd_ptr);
    full_o    = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
    wr_accept = wr_en_i && !full_o;
    rd_accept = rd_en_i && !empty_o;
  end

  // ---- stage p1: pointer advance and error pulses ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_error_p1 <= 1'b0;
      rd_error_p1 <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      wr_error_p1 <= wr_en_i && full_o;
      rd_error_p1 <= rd_en_i && empty_o;
    end
  end

  assign wr_error_o = wr_error_p1;
  assign rd_error_o = rd_error_p1;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[PTR_WIDTH-1:0]),
    .wr_data (wdata_i),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[PTR_WIDTH-1:0]),
    .rd_data (rdata_o)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue-based scoreboard: values are
// pushed when a write should be accepted and popped when a read should be.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             wr_en_i = 1'b0;
  logic [WIDTH-1:0] wdata_i = '0;
  logic             rd_en_i = 1'b0;
  logic [WIDTH-1:0] rdata_o;
  logic             full_o;
  logic             empty_o;
  logic             wr_error_o;
  logic             rd_error_o;

  int               errors = 0;
  int               checks = 0;
  int               step_no = 0;
  int               wr_err_seen = 0;
  int               rd_err_seen = 0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_rdata = '0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH($clog2(DEPTH))) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wdata_i    (wdata_i),
    .rd_en_i    (rd_en_i),
    .rdata_o    (rdata_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .wr_error_o (wr_error_o),
    .rd_error_o (rd_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e_wr_err, input logic e_rd_err);
    chk({tag, ".rdata"},  32'(rdata_o),    32'(exp_rdata));
    chk({tag, ".full"},   32'(full_o),     32'(sb.size() == DEPTH));
    chk({tag, ".empty"},  32'(empty_o),    32'(sb.size() == 0));
    chk({tag, ".wr_err"}, 32'(wr_error_o), 32'(e_wr_err));
    chk({tag, ".rd_err"}, 32'(rd_error_o), 32'(e_rd_err));
  endtask

  // One clock of stimulus: called just after an edge, drives inputs, updates
  // the scoreboard from the pre-edge occupancy, then checks after the edge.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    logic was_full;
    logic was_empty;
    logic e_wr_err;
    logic e_rd_err;
    was_full  = (sb.size() == DEPTH);
    was_empty = (sb.size() == 0);
    wr_en_i = wr;
    rd_en_i = rd;
    wdata_i = d;
    e_wr_err = wr && was_full;
    e_rd_err = rd && was_empty;
    if (rd && !was_empty) exp_rdata = sb.pop_front();
    if (wr && !was_full) sb.push_back(d);
    @(posedge clk_i);
    #1;
    step_no++;
    if (wr_error_o) wr_err_seen++;
    if (rd_error_o) rd_err_seen++;
    chk_flags(tag, e_wr_err, e_rd_err);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  initial begin
    // Reset for two cycles.
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_flags("RESET", 1'b0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // ALL_WRITES then WRITE_ERROR.
    for (int i = 0; i < DEPTH; i++) step("ALL_WRITES", 1'b1, 1'b0, 8'(8'hA0 + i));
    chk("ALL_WRITES.full_after16", 32'(full_o), 32'd1);
    step("WRITE_ERROR", 1'b1, 1'b0, 8'h5A);
    chk("WRITE_ERROR.pulse", 32'(wr_error_o), 32'd1);
    step("WRITE_ERROR.idle", 1'b0, 1'b0, 8'h00);

    // ALL_READS then READ_ERROR.
    for (int i = 0; i < DEPTH; i++) step("ALL_READS", 1'b0, 1'b1, 8'h00);
    chk("ALL_READS.last", 32'(rdata_o), 32'hAF);
    chk("ALL_READS.empty_after16", 32'(empty_o), 32'd1);
    step("READ_ERROR", 1'b0, 1'b1, 8'h00);
    chk("READ_ERROR.pulse", 32'(rd_error_o), 32'd1);
    step("READ_ERROR.idle", 1'b0, 1'b0, 8'h00);

    // CONCURRENT_WRITE_READS from empty.
    for (int i = 0; i < DEPTH; i++) step("CONCURRENT", 1'b1, 1'b1, 8'(8'h30 + i));
    step("CONCURRENT.drain", 1'b0, 1'b1, 8'h00);
    chk("CONCURRENT.last", 32'(rdata_o), 32'h3F);

    // N_WRITES_N_READS, N=18.
    wr_err_seen = 0;
    rd_err_seen = 0;
    for (int i = 0; i < 18; i++) step("N_WRITES", 1'b1, 1'b0, 8'(8'h60 + 3 * i));
    chk("N_WRITES.err_pulses", 32'(wr_err_seen), 32'd2);
    for (int i = 0; i < 18; i++) step("N_READS", 1'b0, 1'b1, 8'h00);
    chk("N_READS.err_pulses", 32'(rd_err_seen), 32'd2);

    // Simultaneous requests while full: read wins, write flagged.
    for (int i = 0; i < DEPTH; i++) step("FULL_FILL", 1'b1, 1'b0, 8'(8'hC0 + i));
    step("FULL_BOTH", 1'b1, 1'b1, 8'hEE);
    chk("FULL_BOTH.rdata", 32'(rdata_o), 32'hC0);

    // Mixed traffic exercising repeated pointer wrap.
    for (int i = 0; i < 300; i++)
      step("MIXED", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Asynchronous reset mid-operation discards contents.
    for (int i = 0; i < 5; i++) step("PRE_RST", 1'b1, 1'b0, 8'(8'h11 * i));
    #2 rst_i = 1'b0;
    #1;
    sb.delete();
    exp_rdata = '0;
    chk_flags("ASYNC_RST", 1'b0, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    step("POST_RST.read", 1'b0, 1'b1, 8'h00);
    step("POST_RST.write", 1'b1, 1'b0, 8'h77);
    step("POST_RST.readback", 1'b0, 1'b1, 8'h00);
    chk("POST_RST.value", 32'(rdata_o), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries (power of two, >= 2).
REQ-003 The block SHALL have parameter PTR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 wr_en_i  input  1  write request, sampled at rising clk_i.
REQ-007 wdata_i  input  WIDTH  write data, captured when a write is accepted.
REQ-008 rd_en_i  input  1  read request, sampled at rising clk_i.
REQ-009 rdata_o  output  WIDTH  registered read data.
REQ-010 full_o  output  1  FIFO holds DEPTH entries.
REQ-011 empty_o  output  1  FIFO holds 0 entries.
REQ-012 wr_error_o  output  1  registered pulse: write requested while full.
REQ-013 rd_error_o  output  1  registered pulse: read requested while empty.
REQ-014 Ports SHALL be connectable by name using exactly the names above.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH register array; write and read pointers SHALL be PTR_WIDTH+1 bits (MSB is the wrap toggle bit).
REQ-016 A write SHALL be accepted when wr_en_i=1 and full_o=0: mem[wr_ptr] <= wdata_i; wr_ptr increments by 1 (modulo 2*DEPTH).
REQ-017 A read SHALL be accepted when rd_en_i=1 and empty_o=0: rdata_o <= mem[rd_ptr]; rd_ptr increments by 1; data is visible on rdata_o the cycle after the accepting edge (1-cycle latency).
REQ-018 rdata_o SHALL hold its last value when no read is accepted.
REQ-019 empty_o SHALL be 1 when wr_ptr == rd_ptr (all bits).
REQ-020 full_o SHALL be 1 when the pointer low PTR_WIDTH bits are equal and the MSBs differ.
REQ-021 full_o/empty_o SHALL be combinational from the registered pointers, reflecting the state after the latest edge.
REQ-022 wr_error_o SHALL be 1 for the cycle after an edge where wr_en_i=1 and full_o=1, else 0; the write is dropped and no state changes.
REQ-023 rd_error_o SHALL be 1 for the cycle after an edge where rd_en_i=1 and empty_o=1, else 0; the read is dropped, rdata_o unchanged.
REQ-024 Simultaneous wr_en_i and rd_en_i when neither full nor empty SHALL perform both; occupancy unchanged.
REQ-025 Simultaneous requests when empty: write accepted, read rejected with rd_error_o; when full: read accepted, write rejected with wr_error_o (full/empty evaluated before the edge).
REQ-026 Pointer wrap-around from index DEPTH-1 to 0 SHALL toggle the MSB and preserve FIFO order.

Reset
REQ-027 rst_i=0 SHALL immediately, independent of clk_i, clear wr_ptr, rd_ptr, rdata_o, wr_error_o and rd_error_o to 0, giving empty_o=1, full_o=0.
REQ-028 Array contents SHALL NOT be reset; stale data SHALL never be readable because reads are gated by empty.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; operation resumes on the first rising edge after rst_i returns to 1.

Structure
REQ-030 A shared package fifo_pkg SHALL hold default WIDTH/DEPTH constants only; no typedefs required.
REQ-031 Storage SHALL be a sub-module fifo_mem (one write port, one registered read port); pointer/flag/error logic stays in sync_fifo.

Verification
REQ-032 Reset: rst_i=0 for 2 cycles -> empty_o=1, full_o=0, rdata_o=0, errors 0.
REQ-033 ALL_WRITES: 16 consecutive writes -> full_o=1 after 16th edge, empty_o=0, no wr_error_o.
REQ-034 ALL_WRITES_ALL_READS: 16 writes then 16 reads -> rdata_o returns the 16 written values in order, empty_o=1 after last read.
REQ-035 WRITE_ERROR / READ_ERROR: 17th write -> wr_error_o=1 for one cycle, contents unchanged; 17th read after 16 writes/16 reads -> rd_error_o=1 one cycle.
REQ-036 CONCURRENT_WRITE_READS: 16 writes and 16 reads started the same cycle on empty FIFO -> first read rejected (rd_error_o=1), remaining data in order, never full.
REQ-037 N_WRITES_N_READS with N=18 -> 2 wr_error_o pulses, 16 values read in order, then 2 rd_error_o pulses.
